// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment controller with sequential binary-to-BCD conversion.
// Optional build macro LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero one.
module seg_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [7:0] in,
  input  logic       load,
  output logic       busy,
  output logic       done,
  output logic [6:0] seg,
  output logic [3:0] an
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t          state, state_nxt;
  logic            busy_nxt, done_nxt;
  logic [19:0]     sr, sr_adj, sr_shift;
  logic [2:0]      cnt;
  logic [3:0][3:0] dig;
  logic [PW-1:0]   presc;
  logic [1:0]      idx, idx_nxt;
  logic            blank;
  logic [6:0]      seg_nxt;

  function automatic logic [6:0] decode(input logic [3:0] v);
    unique case (v)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      4'hF: return 7'b0001110;
    endcase
  endfunction

  // Double-dabble step: correct every BCD nibble, then shift the whole register.
  always_comb begin
    sr_adj = sr;
    for (int unsigned i = 0; i < 3; i++) begin
      if (sr[8 + 4*i +: 4] >= 4'd5)
        sr_adj[8 + 4*i +: 4] = sr[8 + 4*i +: 4] + 4'd3;
    end
    sr_shift = sr_adj << 1;
  end

  always_comb begin
    state_nxt = state;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (load) begin
          state_nxt = CONV;
          busy_nxt  = 1'b1;
        end
      end
      CONV: begin
        if (cnt == 3'd7)
          state_nxt = COMMIT;
      end
      COMMIT: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      sr  <= '0;
      cnt <= '0;
      dig <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load) begin
            sr  <= {12'b0, in};
            cnt <= '0;
          end
        end
        CONV: begin
          sr  <= sr_shift;
          cnt <= cnt + 3'd1;
        end
        COMMIT: dig <= {4'd0, sr[19:16], sr[15:12], sr[11:8]};
        default: ;
      endcase
    end
  end

  assign idx_nxt = idx + 2'd1;

`ifdef LEADING_ZERO_BLANK_EN
  logic [1:0] msd;

  always_comb begin
    msd = 2'd0;
    if (dig[3] != 4'd0)      msd = 2'd3;
    else if (dig[2] != 4'd0) msd = 2'd2;
    else if (dig[1] != 4'd0) msd = 2'd1;
    blank = (idx_nxt > msd);
  end
`else
  assign blank = 1'b0;
`endif

  assign seg_nxt = blank ? 7'b1111111 : decode(dig[idx_nxt]);

  // Segment/anode registers change only when the scan slot advances.
  always_ff @(posedge clk) begin
    if (clr) begin
      presc <= '0;
      idx   <= '0;
      an    <= 4'b1110;
      seg   <= 7'b1000000;
    end else if (presc == PRESC_LAST) begin
      presc <= '0;
      idx   <= idx_nxt;
      an    <= ~(4'b0001 << idx_nxt);
      seg   <= seg_nxt;
    end else begin
      presc <= presc + PW'(1);
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: decimal reference model, done-timing queue, per-cycle display check.
module tb_seg_scan_ctrl;

  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [7:0] in = '0;
  logic       load = 1'b0;
  logic       busy, done;
  logic [6:0] seg;
  logic [3:0] an;

  seg_scan_ctrl #(.SCAN_DIV(SD)) dut (
    .clk(clk), .clr(clr), .in(in), .load(load),
    .busy(busy), .done(done), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  typedef struct {
    int val;
    int dedge;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  bit   chk_en = 0;

  int         ecount = 0;
  bit         pend = 0;
  int         pend_val = 0;
  int         pend_edge = 0;
  int         disp_val = 0;
  int         presc_m = 0;
  int         idx_m = 0;
  logic [6:0] exp_seg = 7'b1000000;
  logic [3:0] exp_an = 4'b1110;

  logic [6:0] pats [10];
  int         p10 [4];

  initial begin
    pats = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    p10  = '{1, 10, 100, 1000};
  end

  function automatic logic [6:0] pattern(input int val, input int i);
`ifdef LEADING_ZERO_BLANK_EN
    if (i > 0 && val < p10[i]) return 7'b1111111;
`endif
    return pats[(val / p10[i]) % 10];
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", nm, ecount, act, exp);
    end
  endtask

  // Reference model: a conversion is a 9-edge delay from acceptance to showing the decimal value.
  initial begin
    forever begin
      @(posedge clk);
      ecount++;
      if (clr) begin
        pend     = 0;
        q.delete();
        disp_val = 0;
        presc_m  = 0;
        idx_m    = 0;
        exp_an   = 4'b1110;
        exp_seg  = pattern(0, 0);
      end else begin
        if (presc_m == SD - 1) begin
          presc_m = 0;
          idx_m   = (idx_m + 1) % 4;
          exp_an  = 4'b1111 ^ (4'b0001 << idx_m);
          exp_seg = pattern(disp_val, idx_m);
        end else begin
          presc_m++;
        end
        if (pend && ecount == pend_edge) begin
          disp_val = pend_val;
          pend     = 0;
        end else if (!pend && load) begin
          pend      = 1;
          pend_val  = int'(in);
          pend_edge = ecount + 9;
          q.push_back('{int'(in), ecount + 9});
        end
      end
    end
  end

  // Monitor: per-cycle display/busy check and scoreboard pop on every done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("busy", int'(busy), int'(pend));
        chk("an", int'(an), int'(exp_an));
        chk("seg", int'(seg), int'(exp_seg));
        while (q.size() > 0 && q[0].dedge < ecount) begin
          e = q.pop_front();
          chk("done_missing", 0, 1);
        end
        if (done) begin
          if (q.size() == 0) begin
            chk("done_spurious", 1, 0);
          end else begin
            e = q.pop_front();
            chk("done_time", ecount, e.dedge);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [7:0] v);
    in   = v;
    load = 1'b1;
    tick(1);
    load = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    chk_en = 1;
    tick(1);
    clr = 1'b0;
    tick(20);

    do_load(8'd255);
    tick(12);
    tick(20);

    do_load(8'd123);
    tick(2);
    in   = 8'd7;
    load = 1'b1;
    tick(1);
    load = 1'b0;
    tick(12);
    tick(20);

    do_load(8'd200);
    tick(3);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(20);

    do_load(8'd9);
    tick(12);
    tick(20);

    do_load(8'd0);
    tick(12);
    tick(20);

    // Back-to-back: load again in the cycle done is high.
    do_load(8'd58);
    tick(9);
    do_load(8'd147);
    tick(12);
    tick(20);

    for (int i = 0; i < 300; i++) begin
      in   = 8'($urandom_range(0, 255));
      load = ($urandom_range(0, 3) == 0);
      clr  = ($urandom_range(0, 63) == 0);
      tick(1);
    end
    load = 1'b0;
    clr  = 1'b0;
    tick(30);

    chk("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
